serial_accum: RTL and testbench

SERIAL_ACCUM -- requirements
Module: serial_accum

---
 rtl/acc_pkg.sv | 24 ++
 rtl/drum_track_n.sv | 24 ++
 rtl/serial_accum.sv | 134 +++++++++++++
 tb/tb_serial_accum.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared encodings for the serial drum accumulator: command opcodes and
// controller states.
package acc_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    ADD   = 3'd1,
    SUB   = 3'd2,
    LOAD  = 3'd3,
    CLEAR = 3'd4
  } acc_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } acc_state_t;

  function automatic logic op_is_arith(acc_op_t op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage

// File: rtl/drum_track_n.sv
// L-bit serial delay line: the bit presented on rd_bit is the wr_bit
// written exactly L clocks earlier. Asynchronous clear empties the track.
module drum_track_n #(
  parameter int L = 58
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_bit,
  output logic rd_bit
);

  logic [L-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {wr_bit, sr[L-1:1]};
    end
  end

  assign rd_bit = sr[0];

endmodule

// File: rtl/serial_accum.sv
// Bit-serial accumulator over a circulating L-bit track (LSB first). A command
// waits for frame start, runs for one full frame, then pulses done.
module serial_accum
  import acc_pkg::*;
#(
  parameter int WORD_BITS = 29,
  parameter int WORDS     = 2
) (
  input  logic                   CLOCK,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic                   din,
  output logic                   ar,
  output logic                   t1,
  output logic                   tw,
  output logic [$clog2(WORDS):0] word_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   carry_out,
  output logic                   ovf,
  output logic [1:0]             dbg_state
);

  localparam int L     = WORD_BITS * WORDS;
  localparam int BIT_W = $clog2(WORD_BITS);
  localparam int WI_W  = $clog2(WORDS) + 1;

  logic [BIT_W-1:0] bit_cnt;
  logic [WI_W-1:0]  word_cnt;
  logic             last_bit, last_word, frame_end, frame_start;

  acc_state_t state, state_nxt;
  acc_op_t    op_q;
  logic       accept;
  logic       c, c_in, addend, sum, cout, wr_bit;

  // Position counter split into bit-in-word and word index; pos is implied.
  assign last_bit    = (bit_cnt == BIT_W'(WORD_BITS - 1));
  assign last_word   = (word_cnt == WI_W'(WORDS - 1));
  assign frame_end   = last_bit && last_word;
  assign frame_start = (bit_cnt == '0) && (word_cnt == '0);

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (last_bit) begin
      bit_cnt  <= '0;
      word_cnt <= last_word ? '0 : word_cnt + WI_W'(1);
    end else begin
      bit_cnt  <= bit_cnt + BIT_W'(1);
    end
  end

  // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and offers made while busy are dropped.
  assign accept = cmd_valid && (state == IDLE);

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = frame_end ? RUN : ARMED;
      ARMED:   if (frame_end) state_nxt = RUN;
      RUN:     if (frame_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial full adder; SUB adds the inverted operand with carry seeded to 1.
  always_comb begin
    c_in   = frame_start ? (op_q == SUB) : c;
    addend = (op_q == SUB) ? ~din : din;
    sum    = ar ^ addend ^ c_in;
    cout   = (ar & addend) | (c_in & (ar ^ addend));
    wr_bit = ar;
    if (state == RUN) begin
      case (op_q)
        ADD, SUB: wr_bit = sum;
        LOAD:     wr_bit = din;
        CLEAR:    wr_bit = 1'b0;
        default:  wr_bit = ar;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= HOLD;
      c         <= 1'b0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      op_q      <= acc_op_t'(cmd_op);
      c         <= 1'b0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
    end else if ((state == RUN) && op_is_arith(op_q)) begin
      c <= cout;
      if (frame_end) begin
        carry_out <= cout;
        ovf       <= c_in ^ cout;
      end
    end else begin
      c <= 1'b0;
    end
  end

  drum_track_n #(.L(L)) u_track (
    .clk    (CLOCK),
    .rst_n  (rst_n),
    .wr_bit (wr_bit),
    .rd_bit (ar)
  );

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign t1        = (bit_cnt == '0);
  assign tw        = last_bit;
  assign word_idx  = word_cnt;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_accum.sv
// Bench for serial_accum: a small instance (4x2) and a default instance (29x2)
// checked every cycle against a frame-level arithmetic model of the track.
module tb_serial_accum;
  import acc_pkg::*;

  // clock / reset
  logic CLOCK = 1'b0;
  logic rst_n = 1'b1;
  always #5 CLOCK = ~CLOCK;

  logic       vld [2];
  logic       di [2];
  logic [2:0] opc [2];
  logic       rdy [2], ar_o [2], t1_o [2], tw_o [2];
  logic       busy_o [2], done_o [2], co_o [2], ovf_o [2];
  logic [1:0] widx [2], st_o [2];

  serial_accum #(.WORD_BITS(4), .WORDS(2)) u_small (
    .CLOCK(CLOCK), .rst_n(rst_n), .cmd_valid(vld[0]), .cmd_ready(rdy[0]),
    .cmd_op(opc[0]), .din(di[0]), .ar(ar_o[0]), .t1(t1_o[0]), .tw(tw_o[0]),
    .word_idx(widx[0]), .busy(busy_o[0]), .done(done_o[0]),
    .carry_out(co_o[0]), .ovf(ovf_o[0]), .dbg_state(st_o[0])
  );

  serial_accum u_dflt (
    .CLOCK(CLOCK), .rst_n(rst_n), .cmd_valid(vld[1]), .cmd_ready(rdy[1]),
    .cmd_op(opc[1]), .din(di[1]), .ar(ar_o[1]), .t1(t1_o[1]), .tw(tw_o[1]),
    .word_idx(widx[1]), .busy(busy_o[1]), .done(done_o[1]),
    .carry_out(co_o[1]), .ovf(ovf_o[1]), .dbg_state(st_o[1])
  );

  // reference model state per instance
  logic [63:0] m_t [2];
  int          m_pos [2];
  logic        e_busy [2], e_done [2], e_co [2], e_ovf [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic int len_of(int s);
    return (s == 0) ? 8 : 58;
  endfunction

  function automatic int wb_of(int s);
    return (s == 0) ? 4 : 29;
  endfunction

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level result of a command on track value t with operand d.
  function automatic void model(input logic [2:0] op, input logic [63:0] t, input logic [63:0] d,
                                input int l, output logic [63:0] nt, output logic co, output logic ov);
    logic [64:0] mask, sum;
    mask = (65'd1 << l) - 65'd1;
    nt = t;
    co = 1'b0;
    ov = 1'b0;
    case (op)
      ADD: begin
        sum = {1'b0, t} + {1'b0, d};
        nt  = sum[63:0] & mask[63:0];
        co  = sum[l];
        ov  = (t[l-1] == d[l-1]) && (nt[l-1] != t[l-1]);
      end
      SUB: begin
        sum = {1'b0, t} + ({1'b0, ~d} & mask) + 65'd1;
        nt  = sum[63:0] & mask[63:0];
        co  = sum[l];
        ov  = (t[l-1] != d[l-1]) && (nt[l-1] != t[l-1]);
      end
      LOAD:    nt = d & mask[63:0];
      CLEAR:   nt = 64'd0;
      default: nt = t;
    endcase
  endfunction

  task automatic check_cycle();
    for (int s = 0; s < 2; s++) begin
      string sfx;
      sfx = (s == 0) ? "_s" : "_d";
      chk({"t1", sfx},    64'(t1_o[s]),   64'((m_pos[s] % wb_of(s)) == 0));
      chk({"tw", sfx},    64'(tw_o[s]),   64'((m_pos[s] % wb_of(s)) == wb_of(s) - 1));
      chk({"widx", sfx},  64'(widx[s]),   64'(m_pos[s] / wb_of(s)));
      chk({"ar", sfx},    64'(ar_o[s]),   64'(m_t[s][m_pos[s]]));
      chk({"busy", sfx},  64'(busy_o[s]), 64'(e_busy[s]));
      chk({"ready", sfx}, 64'(rdy[s]),    64'(!e_busy[s]));
      chk({"done", sfx},  64'(done_o[s]), 64'(e_done[s]));
      chk({"cout", sfx},  64'(co_o[s]),   64'(e_co[s]));
      chk({"ovf", sfx},   64'(ovf_o[s]),  64'(e_ovf[s]));
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
    for (int s = 0; s < 2; s++) m_pos[s] = (m_pos[s] + 1) % len_of(s);
    check_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      vld[s] = 1'b0; m_pos[s] = 0; m_t[s] = 64'd0;
      e_busy[s] = 1'b0; e_done[s] = 1'b0; e_co[s] = 1'b0; e_ovf[s] = 1'b0;
    end
    #1;
    check_cycle();
    @(negedge CLOCK);
    @(negedge CLOCK);
    rst_n = 1'b1;
  endtask

  // driver: offer at acc_pos, optionally keep cmd_valid high while busy,
  // optionally pulse reset at RUN position rst_at.
  task automatic run_cmd(input int s, input logic [2:0] op, input logic [63:0] d, input int acc_pos,
                         input bit hold, input int rst_at, output int armed);
    int l, guard;
    logic [63:0] nt;
    logic co, ov;
    l = len_of(s);
    armed = 0;
    guard = 0;
    while (m_pos[s] != acc_pos && guard < 2 * l) begin step(); guard++; end
    vld[s] = 1'b1;
    opc[s] = op;
    e_busy[s] = 1'b1; e_co[s] = 1'b0; e_ovf[s] = 1'b0;
    step();
    if (hold) opc[s] = CLEAR;
    else vld[s] = 1'b0;
    guard = 0;
    while (m_pos[s] != 0 && guard < l) begin armed++; step(); guard++; end
    model(op, m_t[s], d, l, nt, co, ov);
    for (int k = 0; k < l; k++) begin
      di[s] = (op == ADD || op == SUB || op == LOAD) ? d[k] : 1'($urandom_range(0, 1));
      if (k == rst_at) begin
        do_reset();
        return;
      end
      if (k == l - 1) begin
        vld[s] = 1'b0;
        m_t[s] = nt; e_co[s] = co; e_ovf[s] = ov; e_done[s] = 1'b1;
      end
      step();
    end
    e_done[s] = 1'b0;
    e_busy[s] = 1'b0;
    step();
  endtask

  int          armed, acc, guard;
  logic [2:0]  op;
  logic [63:0] d;

  initial begin
    for (int s = 0; s < 2; s++) begin
      vld[s] = 1'b0; di[s] = 1'b0; opc[s] = 3'd0;
    end
    #3;
    do_reset();

    run_cmd(0, LOAD, 64'h05, 3, 1'b0, -1, armed);
    repeat (8) step();

    run_cmd(0, LOAD, 64'h0F, 0, 1'b0, -1, armed);
    run_cmd(0, ADD, 64'h01, 5, 1'b0, -1, armed);
    run_cmd(0, LOAD, 64'h7F, 1, 1'b0, -1, armed);
    run_cmd(0, ADD, 64'h01, 6, 1'b0, -1, armed);
    run_cmd(0, CLEAR, 64'h00, 4, 1'b0, -1, armed);
    run_cmd(0, SUB, 64'h01, 3, 1'b0, -1, armed);

    run_cmd(0, HOLD, 64'h00, 7, 1'b1, -1, armed);
    chk("armed_pos7", 64'(armed), 64'd0);
    run_cmd(0, ADD, 64'h33, 2, 1'b0, -1, armed);
    chk("armed_pos2", 64'(armed), 64'd5);

    repeat (40) begin
      op  = 3'($urandom_range(0, 4));
      d   = 64'($urandom_range(0, 255));
      acc = $urandom_range(0, 7);
      run_cmd(0, op, d, acc, 1'($urandom_range(0, 1)), -1, armed);
      chk("armed_rand", 64'(armed), 64'(7 - acc));
      repeat ($urandom_range(0, 3)) step();
    end

    run_cmd(0, LOAD, 64'hA5, 4, 1'b1, -1, armed);
    run_cmd(0, ADD, 64'h5A, 4, 1'b1, 3, armed);
    repeat (10) step();

    run_cmd(1, LOAD, (64'd1 << 29) - 64'd1, 10, 1'b0, -1, armed);
    run_cmd(1, ADD, 64'd1, 57, 1'b0, -1, armed);
    chk("armed_d57", 64'(armed), 64'd0);
    guard = 0;
    while (m_pos[1] != 29 && guard < 60) begin step(); guard++; end
    chk("w1b0_d", 64'(ar_o[1]), 64'd1);

    repeat (6) begin
      op  = 3'($urandom_range(0, 4));
      d   = {$urandom(), $urandom()} & ((64'd1 << 58) - 64'd1);
      acc = $urandom_range(0, 57);
      run_cmd(1, op, d, acc, 1'($urandom_range(0, 1)), -1, armed);
      chk("armed_rand_d", 64'(armed), 64'(57 - acc));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
